// File: rtl/psk_mapper_pkg.sv
// psk_mapper_pkg
//   Shared definitions for the PSK bit mappers: mode encodings, default
//   DAC amplitudes, FSM state type and the symbols-per-word helper.
package psk_mapper_pkg;

  localparam logic MODE_QPSK = 1'b0;
  localparam logic MODE_BPSK = 1'b1;

  // +/-80% of DAC full scale in 16-bit two's complement
  localparam logic [15:0] AMP_POS_DEF = 16'h6665;
  localparam logic [15:0] AMP_NEG_DEF = 16'h999B;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  // Number of symbols one packed word produces in the given mode.
  function automatic int sym_per_word(input logic mode, input int in_w);
    return (mode == MODE_BPSK) ? in_w : in_w / 2;
  endfunction

endpackage

// File: rtl/psk_symbol_lut.sv
// psk_symbol_lut
//   Combinational bit-to-constellation mapping for BPSK/QPSK.
//   Ports:
//     i_bit_i  in   bit for the I branch
//     i_bit_q  in   bit for the Q branch (ignored in BPSK)
//     i_mode   in   MODE_QPSK / MODE_BPSK
//     o_iq     out  {I, Q} samples, SAMP_W bits each
module psk_symbol_lut
  import psk_mapper_pkg::*;
#(
  parameter int                SAMP_W  = 16,
  parameter logic [SAMP_W-1:0] AMP_POS = AMP_POS_DEF,
  parameter logic [SAMP_W-1:0] AMP_NEG = AMP_NEG_DEF
) (
  input  logic                i_bit_i,
  input  logic                i_bit_q,
  input  logic                i_mode,
  output logic [2*SAMP_W-1:0] o_iq
);

  logic [SAMP_W-1:0] w_i;
  logic [SAMP_W-1:0] w_q;

  always_comb begin
    w_i = i_bit_i ? AMP_POS : AMP_NEG;
    w_q = '0;
    if (i_mode == MODE_QPSK) begin
      w_q = i_bit_q ? AMP_POS : AMP_NEG;
    end
  end

  assign o_iq = {w_i, w_q};

endmodule

// File: rtl/psk_bit_mapper.sv
// psk_bit_mapper
//   Serialises packed IN_W-bit words MSB-first into BPSK/QPSK I/Q sample
//   pairs, one symbol per clock, with zero bubble between words.
//   Optional macro PSK_DIFF_ENC_EN adds per-branch differential encoding.
//   Ports:
//     clk, reset (async, active-low)
//     mode                         0 = QPSK, 1 = BPSK, sampled on accept
//     in_tdata/in_tlast/in_tvalid/in_tready    input word stream
//     out_tdata/out_tlast/out_tvalid/out_tready {I,Q} symbol stream
//     idle                         no word held
//
//   state    | meaning
//   ST_EMPTY | no word held, ready for a new one
//   ST_BUSY  | presenting symbols of the held word
module psk_bit_mapper
  import psk_mapper_pkg::*;
#(
  parameter int                IN_W    = 32,
  parameter int                SAMP_W  = 16,
  parameter logic [SAMP_W-1:0] AMP_POS = AMP_POS_DEF,
  parameter logic [SAMP_W-1:0] AMP_NEG = AMP_NEG_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [IN_W-1:0]     in_tdata,
  input  logic                in_tlast,
  input  logic                in_tvalid,
  output logic                in_tready,
  output logic [2*SAMP_W-1:0] out_tdata,
  output logic                out_tlast,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic                idle
);

  localparam int REM_W = $clog2(IN_W) + 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IN_W-1:0]    r_sreg;
  logic [REM_W-1:0]   r_rem;
  logic               r_mode;
  logic               r_last;

  logic               w_busy;
  logic               w_rem_one;
  logic               w_accept;
  logic               w_advance;
  logic               w_bit_i;
  logic               w_bit_q;
  logic [2*SAMP_W-1:0] w_iq;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_rem_one = (r_rem == REM_W'(1));
  // Ready on the last symbol lets the next word load in the same edge
  assign in_tready = !w_busy || (out_tready && w_rem_one);
  assign w_accept  = in_tvalid && in_tready;
  assign w_advance = w_busy && out_tready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_BUSY;
    end else if (w_advance && w_rem_one) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg <= '0;
      r_rem  <= '0;
      r_mode <= MODE_QPSK;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_sreg <= in_tdata;
      r_rem  <= REM_W'(sym_per_word(mode, IN_W));
      r_mode <= mode;
      r_last <= in_tlast;
    end else if (w_advance) begin
      r_sreg <= (r_mode == MODE_BPSK) ? (r_sreg << 1) : (r_sreg << 2);
      r_rem  <= r_rem - REM_W'(1);
    end
  end

`ifdef PSK_DIFF_ENC_EN
  logic r_d_i;
  logic r_d_q;

  assign w_bit_i = r_sreg[IN_W-1] ^ r_d_i;
  assign w_bit_q = r_sreg[IN_W-2] ^ r_d_q;

  // Encoder history follows consumed symbols and restarts per packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_i <= 1'b0;
      r_d_q <= 1'b0;
    end else if (w_advance) begin
      if (out_tlast) begin
        r_d_i <= 1'b0;
        r_d_q <= 1'b0;
      end else begin
        r_d_i <= w_bit_i;
        if (r_mode == MODE_QPSK) begin
          r_d_q <= w_bit_q;
        end
      end
    end
  end
`else
  assign w_bit_i = r_sreg[IN_W-1];
  assign w_bit_q = r_sreg[IN_W-2];
`endif

  psk_symbol_lut #(
    .SAMP_W (SAMP_W),
    .AMP_POS(AMP_POS),
    .AMP_NEG(AMP_NEG)
  ) u_lut (
    .i_bit_i(w_bit_i),
    .i_bit_q(w_bit_q),
    .i_mode (r_mode),
    .o_iq   (w_iq)
  );

  assign out_tvalid = w_busy;
  assign out_tdata  = w_busy ? w_iq : '0;
  assign out_tlast  = r_last && w_rem_one && w_busy;
  assign idle       = !w_busy;

endmodule
